// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction fetch queue between the PC/imem stage and decode.
// Holds {pc, instr} pairs and delivers them in order, with a flush for branch/jump redirects.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an empty queue forward the incoming
// instruction to decode in the same cycle. The default build has registered-only latency.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [WIDTH-1:0]           in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [WIDTH-1:0]           out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013);

  // Storage is never reset; only pointers and occupancy are.
  logic [PC_W-1:0]  r_pc_mem  [DEPTH];
  logic [WIDTH-1:0] r_ins_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_empty;
  logic             w_push;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_out_valid;
  logic [PC_W-1:0]  w_head_pc;
  logic [WIDTH-1:0] w_head_ins;

  // Full blocks pushes even when a pop frees a slot this cycle; flush is not looked at.
  assign in_ready = (r_count < FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_byp;
  // An empty queue forwards the incoming word straight to decode; a flush suppresses it.
  assign w_byp       = w_empty && in_valid && !flush;
  assign w_out_valid = !w_empty || w_byp;
  assign w_head_pc   = w_empty ? in_pc    : r_pc_mem[r_rd_ptr];
  assign w_head_ins  = w_empty ? in_instr : r_ins_mem[r_rd_ptr];
  // A bypassed word that decode takes immediately is never stored.
  assign w_wr_en     = w_push && !(w_byp && out_ready);
`else
  assign w_out_valid = !w_empty;
  assign w_head_pc   = r_pc_mem[r_rd_ptr];
  assign w_head_ins  = r_ins_mem[r_rd_ptr];
  assign w_wr_en     = w_push;
`endif

  // Storage-side pop: only a stored head can be consumed from the buffer.
  assign w_rd_en = !w_empty && out_ready;

  // Idle head shows PC 0 and a NOP so decode never sees stale data.
  assign out_valid = w_out_valid;
  assign out_pc    = w_out_valid ? w_head_pc  : '0;
  assign out_instr = w_out_valid ? w_head_ins : NOP;
  assign count     = r_count;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry write; skipped under reset or flush since that push is discarded anyway.
  always_ff @(posedge clk) begin
    if (rst && !flush && w_wr_en) begin
      r_pc_mem[r_wr_ptr]  <= in_pc;
      r_ins_mem[r_wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus a hand-written wrap sequence for fetch_queue.
// Honours FETCH_QUEUE_BYPASS_EN so the same bench covers both builds.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h0060_0113;
  localparam logic [31:0] I2  = 32'h0070_0193;
  localparam logic [31:0] I3  = 32'h0080_0213;
  localparam logic [31:0] I4  = 32'h0090_0293;
  localparam logic [31:0] IB  = 32'h00A0_0113;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_queue #(.DEPTH(4), .WIDTH(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] pc, ins;
    logic        ordy;
    logic        ir, ov;
    logic [31:0] opc, oins;
    logic [2:0]  cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] pc, logic [31:0] ins,
                              logic ordy, logic ir, logic ov, logic [31:0] opc,
                              logic [31:0] oins, logic [2:0] cnt);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.opc = opc; v.oins = oins; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
  endtask

  vec_t tv [28];
  bit   ops [12];
  logic [31:0] q_pc [$];
  logic [31:0] q_ins [$];

  initial begin
    // Rows: inputs applied, outputs checked before the next rising edge.
    tv[0]  = mk(0,0,0,32'h00,I0,0,  1,0,32'h0,NOP,0);
    tv[1]  = mk(1,0,0,32'h00,I0,0,  1,0,32'h0,NOP,0);
    tv[2]  = mk(1,0,1,32'h00,I0,0,  1,BYP,32'h0,BYP ? I0 : NOP,0);
    tv[3]  = mk(1,0,1,32'h04,I1,0,  1,1,32'h00,I0,1);
    tv[4]  = mk(1,0,1,32'h08,I2,0,  1,1,32'h00,I0,2);
    tv[5]  = mk(1,0,1,32'h0C,I3,0,  1,1,32'h00,I0,3);
    tv[6]  = mk(1,0,1,32'h10,I4,0,  0,1,32'h00,I0,4);
    tv[7]  = mk(1,0,1,32'h10,I4,1,  0,1,32'h00,I0,4);
    tv[8]  = mk(1,0,0,32'h00,I0,1,  1,1,32'h04,I1,3);
    tv[9]  = mk(1,0,0,32'h00,I0,1,  1,1,32'h08,I2,2);
    tv[10] = mk(1,0,0,32'h00,I0,1,  1,1,32'h0C,I3,1);
    tv[11] = mk(1,0,0,32'h00,I0,1,  1,0,32'h00,NOP,0);
    tv[12] = mk(1,0,1,32'h20,I0,0,  1,BYP,BYP ? 32'h20 : 32'h0,BYP ? I0 : NOP,0);
    tv[13] = mk(1,0,1,32'h24,I1,0,  1,1,32'h20,I0,1);
    tv[14] = mk(1,0,1,32'h28,I2,1,  1,1,32'h20,I0,2);
    tv[15] = mk(1,0,0,32'h00,I0,0,  1,1,32'h24,I1,2);
    tv[16] = mk(1,0,1,32'h2C,I3,0,  1,1,32'h24,I1,2);
    tv[17] = mk(1,1,1,32'h30,I4,1,  1,1,32'h24,I1,3);
    tv[18] = mk(1,0,0,32'h00,I0,0,  1,0,32'h00,NOP,0);
    tv[19] = mk(1,0,1,32'h50,I0,0,  1,BYP,BYP ? 32'h50 : 32'h0,BYP ? I0 : NOP,0);
    tv[20] = mk(0,1,1,32'h54,I1,1,  1,1,32'h50,I0,1);
    tv[21] = mk(1,0,0,32'h00,I0,0,  1,0,32'h00,NOP,0);
    tv[22] = mk(1,0,1,32'h40,IB,1,  1,BYP,BYP ? 32'h40 : 32'h0,BYP ? IB : NOP,0);
    tv[23] = mk(1,0,0,32'h00,I0,0,  1,!BYP,BYP ? 32'h0 : 32'h40,BYP ? NOP : IB,BYP ? 3'd0 : 3'd1);
    tv[24] = mk(1,0,0,32'h00,I0,1,  1,!BYP,BYP ? 32'h0 : 32'h40,BYP ? NOP : IB,BYP ? 3'd0 : 3'd1);
    tv[25] = mk(1,0,0,32'h00,I0,0,  1,0,32'h00,NOP,0);
    tv[26] = mk(1,1,1,32'h60,I0,1,  1,0,32'h00,NOP,0);
    tv[27] = mk(1,0,0,32'h00,I0,0,  1,0,32'h00,NOP,0);

    // Reset held low across two rising edges before the table starts.
    drive(0,0,0,32'h0,32'h0,0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].flush, tv[i].iv, tv[i].pc, tv[i].ins, tv[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i),  {31'b0, in_ready},  {31'b0, tv[i].ir});
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, tv[i].ov});
      chk($sformatf("v%0d out_pc", i),    out_pc,             tv[i].opc);
      chk($sformatf("v%0d out_instr", i), out_instr,          tv[i].oins);
      chk($sformatf("v%0d count", i),     {29'b0, count},     {29'b0, tv[i].cnt});
    end

    // Interleaved push/pop across pointer wrap, occupancy kept within 1..3.
    ops = '{1,1,0,1,0,1,0,1,0,1,0,0};
    begin
      int k;
      k = 0;
      for (int s = 0; s < 12; s++) begin
        @(negedge clk);
        if (ops[s]) drive(1,0,1,32'h100 + 32'(4*k),32'h0100_0000 | 32'(k),0);
        else        drive(1,0,0,32'h0,32'h0,1);
        #1;
        chk($sformatf("wrap%0d count", s), {29'b0, count}, 32'(q_pc.size()));
        if (ops[s]) begin
          chk($sformatf("wrap%0d in_ready", s), {31'b0, in_ready}, 32'd1);
          q_pc.push_back(32'h100 + 32'(4*k));
          q_ins.push_back(32'h0100_0000 | 32'(k));
          k++;
        end else begin
          chk($sformatf("wrap%0d out_valid", s), {31'b0, out_valid}, 32'd1);
          chk($sformatf("wrap%0d out_pc", s),    out_pc,    q_pc[0]);
          chk($sformatf("wrap%0d out_instr", s), out_instr, q_ins[0]);
          void'(q_pc.pop_front());
          void'(q_ins.pop_front());
        end
      end
      @(negedge clk);
      drive(1,0,0,32'h0,32'h0,0);
      #1;
      chk("wrap_end count", {29'b0, count}, 32'd0);
      chk("wrap_end out_valid", {31'b0, out_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-002 SHALL have parameter WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter PC_W, default 32, program-counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port flush  input  1  discard all queued entries (branch/jump redirect).
REQ-007 SHALL have port in_valid  input  1  upstream PC register/imem presents a fetched instruction.
REQ-008 SHALL have port in_ready  output  1  queue accepts a push this cycle.
REQ-009 SHALL have port in_pc  input  PC_W  PC of the fetched instruction.
REQ-010 SHALL have port in_instr  input  WIDTH  fetched instruction word.
REQ-011 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-012 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-013 SHALL have port out_pc  output  PC_W  PC of head entry.
REQ-014 SHALL have port out_instr  output  WIDTH  instruction of head entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL be a circular buffer: push = in_valid && in_ready; pop = out_valid && out_ready.
REQ-017 SHALL drive in_ready = (count < DEPTH); when full, in_ready SHALL stay 0 even if a pop occurs that cycle.
REQ-018 SHALL drive out_valid = (count != 0), except as extended by REQ-031.
REQ-019 SHALL drive out_pc/out_instr from the head entry when out_valid=1; when out_valid=0 SHALL drive out_pc=0 and out_instr=32'h00000013 (NOP) zero-extended/truncated to WIDTH.
REQ-020 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 SHALL wrap read and write pointers from DEPTH-1 to 0.
REQ-022 SHALL preserve FIFO order; no entry dropped or duplicated outside flush/reset.
REQ-023 Latency (macro absent): entry pushed at edge N SHALL appear at the outputs with out_valid=1 in the cycle after edge N.
REQ-024 Flush SHALL take priority over push and pop: in a flush cycle both are discarded, and after the edge count=0 and both pointers=0.
REQ-025 in_ready SHALL NOT depend combinationally on flush; a push coinciding with flush is simply lost.
REQ-026 Push with in_valid=1 and in_ready=0 SHALL leave state unchanged; upstream holds in_pc/in_instr until accepted.
REQ-027 Pop with out_valid=0 SHALL have no effect.

Reset
REQ-028 When rst=0 at a rising edge, count, read pointer and write pointer SHALL become 0; storage contents need not be cleared.
REQ-029 During and immediately after reset: out_valid=0, in_ready=1, out_pc=0, out_instr=NOP.
REQ-030 Reset mid-operation SHALL discard all entries exactly as a flush, and SHALL override flush, push and pop in that cycle.

Configuration
REQ-031 With FETCH_QUEUE_BYPASS_EN defined: when count=0, in_valid=1, flush=0, out_valid SHALL be 1 in the same cycle and out_pc/out_instr SHALL equal in_pc/in_instr; if out_ready=1 the entry is consumed without being written (count stays 0), otherwise it is written normally.
REQ-032 Without FETCH_QUEUE_BYPASS_EN: no combinational path from in_* to out_*; latency per REQ-023.

Verification
REQ-033 Reset: rst=0 two cycles then 1 -> count=0, out_valid=0, in_ready=1, out_instr=32'h00000013, out_pc=0.
REQ-034 Fill/drain: out_ready=0, push PCs 0x00,0x04,0x08,0x0C with instrs 0x00500093.. -> count=4, in_ready=0; then out_ready=1 -> same four pop in order, count returns to 0.
REQ-035 Wrap: 6 pushes interleaved with 6 pops at DEPTH=4 while occupancy stays between 1 and 3 -> order preserved across pointer wrap, count never exceeds 4.
REQ-036 Simultaneous: count=2, push and pop same cycle -> count stays 2, head advances to next PC.
REQ-037 Flush: count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, the pushed entry never appears.
REQ-038 Bypass: with FETCH_QUEUE_BYPASS_EN, empty queue, in_pc=0x40, in_instr=0x00A00113, out_ready=1 -> same-cycle out_valid=1, out_pc=0x40, count stays 0; without macro -> out_valid=1 only next cycle.
